// File: rtl/branch_redirect_unit_pkg.sv
// Shared types for the branch redirect unit: FSM encoding and the
// per-branch prediction record flags carried from ID to EX.
package branch_redirect_unit_pkg;

  typedef enum logic {
    NORMAL = 1'b0,
    SQUASH = 1'b1
  } state_t;

  // Wide enough for SQUASH_CYCLES up to 7.
  localparam int SQ_W = 3;

  typedef struct packed {
    logic valid;
    logic pred;
  } rec_flags_t;

endpackage

// File: rtl/branch_redirect_unit_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  always_ff @(posedge Clock) begin
    if (Reset || clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/branch_redirect_unit.sv
// Redirects fetch on predicted-taken ID branches and repairs the PC on EX
// mispredicts, with a short squash window and saturating statistics.
module branch_redirect_unit
  import branch_redirect_unit_pkg::*;
#(
  parameter int AW            = 32,
  parameter int CW            = 16,
  parameter int SQUASH_CYCLES = 1
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Stall,
  input  logic          BranchInstructExists_ID,
  input  logic          Prediction_ID,
  input  logic [AW-1:0] BranchTarget_ID,
  input  logic [AW-1:0] PCPlus4_ID,
  input  logic          BranchInstructExists_EX,
  input  logic          BranchDecision_EX,
  output logic          Redirect,
  output logic [AW-1:0] RedirectPC,
  output logic          Flush_IFID,
  output logic          Flush_IDEX,
  output logic [CW-1:0] BranchCount,
  output logic [CW-1:0] MispredictCount
);

  state_t          state, state_next;
  logic [SQ_W-1:0] sq_cnt, sq_next;

  rec_flags_t      rec;
  logic [AW-1:0]   rec_target;
  logic [AW-1:0]   rec_fallthru;

  logic            mp;
  logic            capture;
  logic            resolve;
  logic [AW-1:0]   correct_pc;

  assign mp         = rec.valid & BranchInstructExists_EX & (rec.pred != BranchDecision_EX);
  assign resolve    = rec.valid & BranchInstructExists_EX;
  assign capture    = BranchInstructExists_ID & ~Stall & (state == NORMAL);
  assign correct_pc = BranchDecision_EX ? rec_target : rec_fallthru;

  // ID->EX record; a mispredict kills it even under Stall.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rec          <= '0;
      rec_target   <= '0;
      rec_fallthru <= '0;
    end else if (mp) begin
      rec.valid <= 1'b0;
    end else if (Stall) begin
      rec <= rec;
    end else if (capture) begin
      rec.valid    <= 1'b1;
      rec.pred     <= Prediction_ID;
      rec_target   <= BranchTarget_ID;
      rec_fallthru <= PCPlus4_ID;
    end else begin
      rec.valid <= 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= NORMAL;
      sq_cnt <= '0;
    end else begin
      state  <= state_next;
      sq_cnt <= sq_next;
    end
  end

  always_comb begin
    state_next = state;
    sq_next    = sq_cnt;
    if (mp) begin
      state_next = SQUASH;
      sq_next    = SQ_W'(SQUASH_CYCLES - 1);
    end else if (state == SQUASH) begin
      if (sq_cnt == '0) begin
        state_next = NORMAL;
      end else begin
        sq_next = sq_cnt - SQ_W'(1);
      end
    end
  end

  // EX repair outranks any ID redirect; nothing is driven while in reset.
  always_comb begin
    Redirect   = 1'b0;
    RedirectPC = '0;
    Flush_IFID = 1'b0;
    Flush_IDEX = 1'b0;
    if (!Reset) begin
      if (mp) begin
        Redirect   = 1'b1;
        RedirectPC = correct_pc;
        Flush_IFID = 1'b1;
        Flush_IDEX = 1'b1;
      end else if (capture && Prediction_ID) begin
        Redirect   = 1'b1;
        RedirectPC = BranchTarget_ID;
        Flush_IFID = 1'b1;
      end
    end
  end

  sat_counter #(.W(CW)) u_branch_count (
    .Clock (Clock),
    .Reset (Reset),
    .inc   (resolve),
    .clear (1'b0),
    .count (BranchCount)
  );

  sat_counter #(.W(CW)) u_mispredict_count (
    .Clock (Clock),
    .Reset (Reset),
    .inc   (mp),
    .clear (1'b0),
    .count (MispredictCount)
  );

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed bench for branch_redirect_unit: a CW=16 and a CW=2 instance share
// stimulus; expected outputs are queued per step and checked mid-cycle.
module tb_branch_redirect_unit;

  localparam int W = 72;

  logic        Clock;
  logic        Reset;
  logic        Stall;
  logic        BranchInstructExists_ID;
  logic        Prediction_ID;
  logic [31:0] BranchTarget_ID;
  logic [31:0] PCPlus4_ID;
  logic        BranchInstructExists_EX;
  logic        BranchDecision_EX;

  logic        redirect, flush_ifid, flush_idex;
  logic [31:0] redirect_pc;
  logic [15:0] branch_count, mispredict_count;

  logic        redirect2, flush_ifid2, flush_idex2;
  logic [31:0] redirect_pc2;
  logic [1:0]  branch_count2, mispredict_count2;

  logic [W-1:0] exp_q[$];
  int vectors;
  int miscompares;

  branch_redirect_unit #(.AW(32), .CW(16), .SQUASH_CYCLES(1)) u_dut (
    .Clock                   (Clock),
    .Reset                   (Reset),
    .Stall                   (Stall),
    .BranchInstructExists_ID (BranchInstructExists_ID),
    .Prediction_ID           (Prediction_ID),
    .BranchTarget_ID         (BranchTarget_ID),
    .PCPlus4_ID              (PCPlus4_ID),
    .BranchInstructExists_EX (BranchInstructExists_EX),
    .BranchDecision_EX       (BranchDecision_EX),
    .Redirect                (redirect),
    .RedirectPC              (redirect_pc),
    .Flush_IFID              (flush_ifid),
    .Flush_IDEX              (flush_idex),
    .BranchCount             (branch_count),
    .MispredictCount         (mispredict_count)
  );

  branch_redirect_unit #(.AW(32), .CW(2), .SQUASH_CYCLES(1)) u_dut_cw2 (
    .Clock                   (Clock),
    .Reset                   (Reset),
    .Stall                   (Stall),
    .BranchInstructExists_ID (BranchInstructExists_ID),
    .Prediction_ID           (Prediction_ID),
    .BranchTarget_ID         (BranchTarget_ID),
    .PCPlus4_ID              (PCPlus4_ID),
    .BranchInstructExists_EX (BranchInstructExists_EX),
    .BranchDecision_EX       (BranchDecision_EX),
    .Redirect                (redirect2),
    .RedirectPC              (redirect_pc2),
    .Flush_IFID              (flush_ifid2),
    .Flush_IDEX              (flush_idex2),
    .BranchCount             (branch_count2),
    .MispredictCount         (mispredict_count2)
  );

  // Clock / reset block
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop one expectation and compare both instances.
  task automatic check_out(input int step_no);
    logic [W-1:0] e;
    string s;
    s = $sformatf("step%0d", step_no);
    cmp({s, "_queue"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      cmp({s, "_redirect"},    32'(redirect),     32'(e[70]));
      cmp({s, "_redirect_pc"}, redirect_pc,       e[69:38]);
      cmp({s, "_flush_ifid"},  32'(flush_ifid),   32'(e[37]));
      cmp({s, "_flush_idex"},  32'(flush_idex),   32'(e[36]));
      cmp({s, "_redirect2"},   32'(redirect2),    32'(e[70]));
      cmp({s, "_redirect_pc2"}, redirect_pc2,     e[69:38]);
      cmp({s, "_flush_ifid2"}, 32'(flush_ifid2),  32'(e[37]));
      cmp({s, "_flush_idex2"}, 32'(flush_idex2),  32'(e[36]));
      if (e[71]) begin
        cmp({s, "_branch_count"},      32'(branch_count),      32'(e[35:20]));
        cmp({s, "_mispredict_count"},  32'(mispredict_count),  32'(e[19:4]));
        cmp({s, "_branch_count2"},     32'(branch_count2),     32'(e[3:2]));
        cmp({s, "_mispredict_count2"}, 32'(mispredict_count2), 32'(e[1:0]));
      end
    end
  endtask

  int step_no;

  // Driver: apply one cycle of inputs, queue expectations, check at negedge.
  task automatic step(input logic st, input logic bid, input logic pid,
                      input logic [31:0] tgt, input logic [31:0] pc4,
                      input logic bex, input logic dex,
                      input logic er, input logic [31:0] epc,
                      input logic ef1, input logic ef2,
                      input int ebc, input int emc);
    logic [1:0] ebc2, emc2;
    ebc2 = (ebc > 3) ? 2'd3 : 2'(ebc);
    emc2 = (emc > 3) ? 2'd3 : 2'(emc);
    Stall                   = st;
    BranchInstructExists_ID = bid;
    Prediction_ID           = pid;
    BranchTarget_ID         = tgt;
    PCPlus4_ID              = pc4;
    BranchInstructExists_EX = bex;
    BranchDecision_EX       = dex;
    exp_q.push_back({1'b1, er, epc, ef1, ef2, 16'(ebc), 16'(emc), ebc2, emc2});
    @(negedge Clock);
    check_out(step_no);
    step_no++;
    @(posedge Clock);
    #1;
  endtask

  task automatic idle(input int ebc, input int emc);
    step(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 0, 0, ebc, emc);
  endtask

  // Reset cycle with a qualifying ID branch present: outputs must stay 0.
  task automatic rst_cycle(input logic bid, input logic pid, input logic [31:0] tgt);
    Reset                   = 1'b1;
    Stall                   = 1'b0;
    BranchInstructExists_ID = bid;
    Prediction_ID           = pid;
    BranchTarget_ID         = tgt;
    PCPlus4_ID              = 32'h4;
    BranchInstructExists_EX = 1'b1;
    BranchDecision_EX       = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0, 16'h0, 2'h0, 2'h0});
    @(negedge Clock);
    check_out(step_no);
    step_no++;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    step_no     = 0;
    Reset = 1'b1;
    Stall = 1'b0;
    BranchInstructExists_ID = 1'b0;
    Prediction_ID = 1'b0;
    BranchTarget_ID = '0;
    PCPlus4_ID = '0;
    BranchInstructExists_EX = 1'b0;
    BranchDecision_EX = 1'b0;

    rst_cycle(1, 1, 32'h100);
    idle(0, 0);

    // 1: predicted taken, resolved taken
    step(0, 1, 1, 32'h100, 32'h24, 0, 0, 1, 32'h100, 1, 0, 0, 0);
    step(0, 0, 0, 32'h0,   32'h0,  1, 1, 0, 32'h0,   0, 0, 0, 0);
    idle(1, 0);

    // 2: predicted not taken, resolved taken; squash cycle ignores ID
    step(0, 1, 0, 32'h200, 32'h48, 0, 0, 0, 32'h0,   0, 0, 1, 0);
    step(0, 0, 0, 32'h0,   32'h0,  1, 1, 1, 32'h200, 1, 1, 1, 0);
    step(0, 1, 1, 32'h500, 32'h30, 0, 0, 0, 32'h0,   0, 0, 2, 1);
    step(0, 0, 0, 32'h0,   32'h0,  1, 0, 0, 32'h0,   0, 0, 2, 1);
    idle(2, 1);

    // 3: predicted taken, resolved not taken; EX beats a same-cycle ID redirect
    step(0, 1, 1, 32'h300, 32'h64, 0, 0, 1, 32'h300, 1, 0, 2, 1);
    step(0, 1, 1, 32'h400, 32'h68, 1, 0, 1, 32'h64,  1, 1, 2, 1);
    idle(3, 2);

    // 4: stall holds the record and suppresses ID redirects
    step(0, 1, 0, 32'h80,  32'h14, 0, 0, 0, 32'h0,   0, 0, 3, 2);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 32'h900, 32'h40, 0, 0, 0, 32'h0, 0, 0, 3, 2);
    end
    step(0, 0, 0, 32'h0,   32'h0,  1, 1, 1, 32'h80,  1, 1, 3, 2);
    idle(4, 3);

    // 5: five mispredicts; CW=2 instance saturates at 3
    rst_cycle(0, 0, 32'h0);
    idle(0, 0);
    for (int i = 0; i < 5; i++) begin
      logic [31:0] t, f;
      t = 32'h1000 + 32'(i) * 32'h10;
      f = 32'h2000 + 32'(i) * 32'h4;
      step(0, 1, 0, t, f, 0, 0, 0, 32'h0, 0, 0, i, i);
      step((i == 2), 0, 0, 32'h0, 32'h0, 1, 1, 1, t, 1, 1, i, i);
      idle(i + 1, i + 1);
    end

    // 6: reset while squashing, then an immediate ID redirect
    step(0, 1, 0, 32'h600, 32'h58, 0, 0, 0, 32'h0,   0, 0, 5, 5);
    step(0, 0, 0, 32'h0,   32'h0,  1, 1, 1, 32'h600, 1, 1, 5, 5);
    rst_cycle(1, 1, 32'h700);
    step(0, 1, 1, 32'h700, 32'h70, 0, 0, 1, 32'h700, 1, 0, 0, 0);
    idle(0, 0);

    cmp("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_redirect_unit.md
Name: branch_redirect_unit

Overview:
- Sits directly downstream of the branch predictor, between it and the IF/ID/EX pipeline control.
- Acts on the predictor's Prediction in ID: redirects fetch to the branch target when a branch is predicted taken.
- Carries each prediction record to EX and compares it with the resolved outcome. On a mispredict it flushes the wrong-path stages and redirects the PC to the correct address.
- Keeps saturating branch and mispredict statistics counters.

Parameters:
AW, 32, PC/address width
CW, 16, statistics counter width
SQUASH_CYCLES, 1, cycles after a mispredict during which ID predictions are ignored (1..7)

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high
Stall  in  1  pipeline stall; holds the ID->EX record
BranchInstructExists_ID  in  1  branch instruction in ID
Prediction_ID  in  1  predictor output for the ID branch (1 = taken)
BranchTarget_ID  in  AW  computed branch target in ID
PCPlus4_ID  in  AW  fall-through address of the ID branch
BranchInstructExists_EX  in  1  branch instruction in EX
BranchDecision_EX  in  1  resolved outcome (1 = taken)
Redirect  out  1  PC mux select: load RedirectPC
RedirectPC  out  AW  next-fetch address when Redirect = 1
Flush_IFID  out  1  squash the IF/ID register
Flush_IDEX  out  1  squash the ID/EX register
BranchCount  out  CW  resolved branches, saturating
MispredictCount  out  CW  mispredicts, saturating

Behaviour:
- Record register (valid, pred, target, fallthru), updated on the rising edge:
  - captures {1, Prediction_ID, BranchTarget_ID, PCPlus4_ID} when BranchInstructExists_ID=1, Stall=0, state=NORMAL;
  - holds while Stall=1;
  - otherwise clears valid.
- Mispredict (combinational): mp = valid & BranchInstructExists_EX & (pred != BranchDecision_EX).
- Correct PC: BranchDecision_EX ? target : fallthru.
- Outputs are combinational from the current inputs, record and state. Priority order:
  1. mp=1: Redirect=1, RedirectPC=correct PC, Flush_IFID=1, Flush_IDEX=1. Overrides any ID prediction in the same cycle and is not gated by Stall.
  2. Otherwise, if state=NORMAL, BranchInstructExists_ID=1, Prediction_ID=1 and Stall=0: Redirect=1, RedirectPC=BranchTarget_ID, Flush_IFID=1, Flush_IDEX=0.
  3. Otherwise all four outputs are 0.
- On mp at a clock edge: record valid clears (no capture in that cycle), state goes to SQUASH, squash counter loads SQUASH_CYCLES-1.
- FSM states are NORMAL and SQUASH:
  - NORMAL -> SQUASH on mp.
  - SQUASH decrements the counter each cycle and returns to NORMAL when counter=0 (i.e. after SQUASH_CYCLES cycles).
  - mp cannot occur in SQUASH because record valid is 0. If it does, the counter reloads.
  - In SQUASH, no ID redirect and no capture.
- BranchInstructExists_EX=1 with valid=0: no redirect, no counter change.
- Counters:
  - BranchCount += 1 on each edge where valid & BranchInstructExists_EX.
  - MispredictCount += 1 on each edge with mp.
  - Both saturate at 2^CW-1; no wrap.
- Reset (any cycle, including mid-squash or with a valid record):
  - record cleared; state=NORMAL; squash counter=0; counters=0;
  - all outputs 0 during and after the Reset cycle until new inputs qualify.
- Latency:
  - ID redirect takes effect at the next edge (0-cycle combinational path).
  - A mispredict is detected in the cycle the branch sits in EX, one edge after capture with no stall.

Decomposition:
- Shared package holds the FSM state encoding (NORMAL=0, SQUASH=1) and the record struct/field widths.
- One natural sub-module: sat_counter (width CW, inc, clear, synchronous Reset), instantiated twice.

Test Plan:
1. Reset; branch in ID with Prediction_ID=1, BranchTarget_ID=0x100, PCPlus4_ID=0x24 -> same cycle Redirect=1, RedirectPC=0x100, Flush_IFID=1. Next cycle EX with BranchDecision_EX=1 -> no redirect, BranchCount=1, MispredictCount=0.
2. Prediction_ID=0, target 0x200, fallthru 0x48; EX decides taken -> Redirect=1, RedirectPC=0x200, both flushes=1, MispredictCount=1. With SQUASH_CYCLES=1, an ID branch predicted taken in the next cycle is ignored (Redirect=0).
3. Predicted taken, target 0x300, fallthru 0x64; EX not taken -> RedirectPC=0x64, both flushes=1. Same cycle an ID branch predicted taken to 0x400 -> EX wins, RedirectPC=0x64.
4. Capture branch (target 0x80, fallthru 0x14, pred=0), then Stall=1 for 3 cycles -> record held, ID redirect suppressed. Release; EX decides taken -> RedirectPC=0x80.
5. CW=2: drive 5 mispredicts -> MispredictCount saturates at 3, BranchCount=3.
6. Reset asserted in the cycle after a mispredict (in SQUASH) -> next cycle state NORMAL, counters 0. A fresh predicted-taken ID branch redirects immediately.
